// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide, one bit per cycle, with divide-by-zero and signed-overflow shortcuts.
module mdu_iter #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    localparam logic [XLEN-1:0]  MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(XLEN - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic              neg_a_q, neg_a_d;
    logic              neg_b_q, neg_b_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              in_neg_a, in_neg_b;
    logic [XLEN-1:0]   a_abs, b_abs;
    logic              div_zero, div_ovf;
    logic [XLEN-1:0]   special_res;

    logic              is_div;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic              div_ge;
    logic [XLEN-1:0]   div_diff;
    logic [XLEN-1:0]   hi_step, lo_step;
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix;
    logic [XLEN-1:0]   final_res;

    // MULHSU treats only rs1 as signed; MUL's low half is sign-agnostic.
    assign in_neg_a = a_i[XLEN-1] & ((op == 3'd1) | (op == 3'd2) | (op == 3'd4) | (op == 3'd6));
    assign in_neg_b = b_i[XLEN-1] & ((op == 3'd1) | (op == 3'd4) | (op == 3'd6));
    assign a_abs    = in_neg_a ? -a_i : a_i;
    assign b_abs    = in_neg_b ? -b_i : b_i;

    assign div_zero    = op[2] & (b_i == '0);
    assign div_ovf     = ((op == 3'd4) | (op == 3'd6)) & (a_i == MIN_NEG) & (b_i == '1);
    assign special_res = div_zero ? (op[1] ? a_i : '1) : (op[1] ? '0 : MIN_NEG);

    // hi/lo hold {product high, multiplier/product low} or {remainder, dividend/quotient}.
    assign is_div    = op_q[2];
    assign mul_sum   = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opnd_q : '0)};
    assign div_shift = {hi_q, lo_q[XLEN-1]};
    assign div_ge    = (div_shift >= {1'b0, opnd_q});
    assign div_diff  = div_shift[XLEN-1:0] - opnd_q;

    assign hi_step = is_div ? (div_ge ? div_diff : div_shift[XLEN-1:0]) : mul_sum[XLEN:1];
    assign lo_step = is_div ? {lo_q[XLEN-2:0], div_ge} : {mul_sum[0], lo_q[XLEN-1:1]};

    assign prod     = {hi_step, lo_step};
    assign prod_fix = (neg_a_q ^ neg_b_q) ? -prod : prod;
    assign quo_fix  = (neg_a_q ^ neg_b_q) ? -lo_step : lo_step;
    assign rem_fix  = neg_a_q ? -hi_step : hi_step;

    always_comb begin
        case (op_q)
            3'd0:                final_res = prod_fix[XLEN-1:0];
            3'd1, 3'd2, 3'd3:    final_res = prod_fix[2*XLEN-1:XLEN];
            3'd4, 3'd5:          final_res = quo_fix;
            default:             final_res = rem_fix;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        opnd_d   = opnd_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        result_d = result_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        if (flush) begin
            state_d = IDLE;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    busy_d = 1'b0;
                    if (start) begin
                        op_d    = op;
                        neg_a_d = in_neg_a;
                        neg_b_d = in_neg_b;
                        opnd_d  = op[2] ? b_abs : a_abs;
                        hi_d    = '0;
                        lo_d    = op[2] ? a_abs : b_abs;
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                        if (div_zero | div_ovf) begin
                            state_d  = DONE;
                            done_d   = 1'b1;
                            result_d = special_res;
                        end else begin
                            state_d = CALC;
                        end
                    end
                end
                CALC: begin
                    hi_d  = hi_step;
                    lo_d  = lo_step;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_d  = DONE;
                        done_d   = 1'b1;
                        result_d = final_res;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
                default: begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            opnd_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            opnd_q   <= opnd_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed RV32M cases, handshake corners and
// random operations checked against a 64-bit arithmetic reference model.
module tb_mdu_iter;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        flush;
    logic [2:0]  op;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int          n_checks;
    int          n_fail;
    logic [31:0] last_exp;

    mdu_iter #(.XLEN(32), .CNT_W(6)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .flush  (flush),
        .op     (op),
        .a_i    (a_i),
        .b_i    (b_i),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

    // RV32M semantics expressed directly with 64-bit integer arithmetic.
    function automatic logic [31:0] refModel(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        p  = '0;
        case (o)
            3'd0: begin p = 64'(sa * sb); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = 64'(ua * ub); return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFFFFFF;
                p = 64'(sa / sb);
                return p[31:0];
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFFFFFF;
                p = 64'(ua / ub);
                return p[31:0];
            end
            3'd6: begin
                if (b == 32'd0) return a;
                p = 64'(sa % sb);
                return p[31:0];
            end
            default: begin
                if (b == 32'd0) return a;
                p = 64'(ua % ub);
                return p[31:0];
            end
        endcase
    endfunction

    function automatic bit isSpecial(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        return o[2] && ((b == 32'd0) ||
               (((o == 3'd4) || (o == 3'd6)) && (a == 32'h80000000) && (b == 32'hFFFFFFFF)));
    endfunction

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'h80000000;
            2:       return 32'hFFFFFFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Presents one request for a single cycle, then scrambles the operand inputs.
    task automatic applyStimulus(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op    = o;
        a_i   = a;
        b_i   = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        op    = 3'($urandom_range(0, 7));
        a_i   = $urandom;
        b_i   = $urandom;
    endtask

    task automatic waitDone(input logic [31:0] hold_val, output int cyc, output bit busy_all, output bit held);
        cyc      = 0;
        busy_all = 1'b1;
        held     = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            if (!busy) busy_all = 1'b0;
            if (done) begin
                cyc = c;
                break;
            end
            if (result !== hold_val) held = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic watchNoDone(input string tag, input int n);
        int cnt;
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done) cnt++;
        end
        checkOutput(tag, 32'(cnt), 32'd0);
    endtask

    task automatic runOp(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res);
        int cyc;
        bit busy_all, held;
        applyStimulus(o, a, b);
        waitDone(last_exp, cyc, busy_all, held);
        checkOutput({tag, "_lat"}, 32'(cyc), isSpecial(o, a, b) ? 32'd1 : 32'd33);
        checkOutput({tag, "_busy"}, 32'(busy_all), 32'd1);
        checkOutput({tag, "_hold"}, 32'(held), 32'd1);
        checkOutput({tag, "_res"}, result, exp_res);
        @(negedge clk);
        checkOutput({tag, "_pulse"}, {31'b0, done}, 32'd0);
        checkOutput({tag, "_idle"}, {31'b0, busy}, 32'd0);
        last_exp = exp_res;
    endtask

    initial begin
        int          cyc;
        bit          busy_all, held;
        logic [2:0]  ro;
        logic [31:0] ra, rb, r1, r2;

        n_checks = 0;
        n_fail   = 0;
        last_exp = 32'd0;
        rst_n    = 1'b0;
        start    = 1'b0;
        flush    = 1'b0;
        op       = 3'd0;
        a_i      = 32'd0;
        b_i      = 32'd0;

        repeat (2) @(negedge clk);
        checkOutput("rst_busy", {31'b0, busy}, 32'd0);
        checkOutput("rst_done", {31'b0, done}, 32'd0);
        checkOutput("rst_result", result, 32'd0);
        rst_n = 1'b1;

        runOp("mul", 3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB);
        runOp("mulh", 3'd1, 32'h80000000, 32'h80000000, 32'h40000000);
        runOp("mulhsu", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
        runOp("mulhu", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
        runOp("div", 3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD);
        runOp("rem", 3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF);
        runOp("divu", 3'd5, 32'd100, 32'd7, 32'd14);
        runOp("remu", 3'd7, 32'd100, 32'd7, 32'd2);
        runOp("div_by0", 3'd4, 32'd5, 32'd0, 32'hFFFFFFFF);
        runOp("remu_by0", 3'd7, 32'd5, 32'd0, 32'd5);
        runOp("div_ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
        runOp("rem_ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0);

        for (int i = 0; i < 24; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = pickOperand();
            rb = pickOperand();
            runOp($sformatf("rnd%0d_op%0d", i, ro), ro, ra, rb, refModel(ro, ra, rb));
        end

        // Start pulses at cycles 5 and 20 of a running divide must be ignored.
        @(negedge clk);
        op = 3'd5; a_i = 32'd1000; b_i = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        for (int c = 1; c <= 40; c++) begin
            if (done) begin
                cyc = c;
                break;
            end
            start = (c == 5) || (c == 20);
            op    = 3'($urandom_range(0, 7));
            a_i   = $urandom;
            b_i   = $urandom;
            @(negedge clk);
        end
        start = 1'b0;
        checkOutput("ign_start_lat", 32'(cyc), 32'd33);
        checkOutput("ign_start_res", result, 32'd333);
        last_exp = 32'd333;
        watchNoDone("ign_start_single_done", 40);
        checkOutput("ign_start_res_kept", result, 32'd333);

        // Flush in cycle 10 aborts without a done pulse.
        applyStimulus(3'd3, $urandom, $urandom);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checkOutput("flush_busy", {31'b0, busy}, 32'd0);
        checkOutput("flush_done", {31'b0, done}, 32'd0);
        checkOutput("flush_res", result, last_exp);
        watchNoDone("flush_no_done", 40);
        checkOutput("flush_res_kept", result, last_exp);

        // start together with flush is not accepted (a divide by zero would finish at once).
        @(negedge clk);
        op = 3'd4; a_i = 32'd9; b_i = 32'd0; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        checkOutput("stflush_busy", {31'b0, busy}, 32'd0);
        checkOutput("stflush_done", {31'b0, done}, 32'd0);
        watchNoDone("stflush_no_done", 5);
        checkOutput("stflush_res", result, last_exp);

        // Back-to-back: start held through DONE is ignored there, accepted in the following IDLE cycle.
        r1 = refModel(3'd0, 32'h12345678, 32'h9ABCDEF0);
        r2 = refModel(3'd6, 32'hDEADBEEF, 32'd12345);
        applyStimulus(3'd0, 32'h12345678, 32'h9ABCDEF0);
        waitDone(last_exp, cyc, busy_all, held);
        checkOutput("b2b_first_lat", 32'(cyc), 32'd33);
        checkOutput("b2b_first_res", result, r1);
        last_exp = r1;
        op = 3'd6; a_i = 32'hDEADBEEF; b_i = 32'd12345; start = 1'b1;
        @(negedge clk);
        checkOutput("b2b_done_ignored", {31'b0, busy}, 32'd0);
        @(negedge clk);
        start = 1'b0;
        a_i = $urandom;
        b_i = $urandom;
        waitDone(r1, cyc, busy_all, held);
        checkOutput("b2b_second_lat", 32'(cyc), 32'd33);
        checkOutput("b2b_second_busy", 32'(busy_all), 32'd1);
        checkOutput("b2b_first_held", 32'(held), 32'd1);
        checkOutput("b2b_second_res", result, r2);
        last_exp = r2;
        @(negedge clk);

        // Asynchronous reset in the middle of an operation.
        applyStimulus(3'd1, $urandom, $urandom);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_busy", {31'b0, busy}, 32'd0);
        checkOutput("midrst_done", {31'b0, done}, 32'd0);
        checkOutput("midrst_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        last_exp = 32'd0;
        watchNoDone("midrst_no_done", 40);
        checkOutput("midrst_result_kept", result, 32'd0);
        runOp("after_rst", 3'd5, 32'hFFFFFFFF, 32'd16, 32'h0FFFFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Iterative RV32M multiply/divide unit in the EX stage, fed with the same rs1/rs2 operands as the main ALU.
- Handles all eight M-extension ops with a start/busy/done handshake.
- The hazard unit stalls IF/ID/EX while busy is high.
- done qualifies result for the EX/MEM result mux.

Parameters:
- XLEN, 32, operand/result width (only 32 supported).
- CNT_W, 6, iteration counter width (holds 0..XLEN).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- flush  input  1  pipeline flush; aborts any operation
- op  input  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- a_i  input  32  rs1 operand (dividend / multiplicand)
- b_i  input  32  rs2 operand (divisor / multiplier)
- busy  output  1  high in CALC and DONE
- done  output  1  one-cycle pulse, result valid
- result  output  32  registered result

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; busy=0, done=0, result=0; counter and internal accumulators cleared.
- States: IDLE, CALC, DONE.
- IDLE:
  - On start=1 & flush=0: latch op, a_i, b_i.
  - For signed operands (op 1,4,6 both; op 2 a only), record the sign and store the absolute value.
  - Special cases go directly to DONE:
    - Divide by zero (op 4..7, b_i=0): DIV/DIVU -> 32'hFFFFFFFF; REM/REMU -> a_i.
    - Signed overflow (op 4/6, a_i=32'h80000000, b_i=32'hFFFFFFFF): DIV -> 32'h80000000, REM -> 0.
  - Otherwise: counter=0, go to CALC.
- CALC:
  - One radix-2 iteration per cycle, exactly 32 cycles (counter 0..31).
  - Multiply: shift-add into a 64-bit unsigned product.
  - Divide: restoring shift-subtract, giving 32-bit quotient and remainder.
  - After iteration 31, apply the sign fix, select the result, register it, and go to DONE.
- Result selection:
  - MUL: low 32 bits of the product.
  - MULH/MULHSU/MULHU: high 32 bits.
  - Product negated when operand signs differ (signed forms).
  - Quotient negated when dividend sign != divisor sign.
  - Remainder takes the dividend sign.
- DONE:
  - done=1 for exactly one cycle, then IDLE.
  - start during DONE is ignored.
- Latency, counted from the clock edge sampling start:
  - Normal op: done high in cycle 33 after that edge.
  - Special case: done high in cycle 1 after that edge.
- result holds its value from DONE until the next special-case or CALC completion.
- result does not change on start, flush, or in IDLE.
- start while busy is ignored; operands are not re-sampled.
- flush=1 in any state forces IDLE on the next edge.
  - No done pulse; result keeps its last completed value.
  - flush has priority over start.
- rst_n deassertion mid-operation: the block resumes from IDLE; the aborted op is lost with no done.
- Operand inputs may change freely after the accepting edge.

Test Plan:
- Reset: rst_n=0 mid-CALC -> busy=0, done=0, result=0 immediately; no done after release.
- Multiply:
  - MUL 7*-3 -> result 32'hFFFFFFEB, done pulse in cycle 33, busy high cycles 1..33.
  - MULH 32'h80000000*32'h80000000 -> 32'h40000000.
  - MULHSU 32'hFFFFFFFF*32'hFFFFFFFF -> 32'hFFFFFFFF.
  - MULHU 32'hFFFFFFFF*32'hFFFFFFFF -> 32'hFFFFFFFE.
- Divide:
  - DIV -7/2 -> 32'hFFFFFFFD.
  - REM -7/2 -> 32'hFFFFFFFF.
  - DIVU 100/7 -> 14.
  - REMU 100/7 -> 2.
- Special cases:
  - DIV 5/0 -> 32'hFFFFFFFF; REMU 5/0 -> 5; both with done in cycle 1.
  - DIV 32'h80000000/32'hFFFFFFFF -> 32'h80000000; REM of the same -> 0.
- Handshake:
  - start pulsed at cycles 5 and 20 of a running op -> ignored, single done.
  - flush at CALC cycle 10 -> IDLE next cycle, no done, result unchanged.
  - start with flush in the same cycle -> not accepted.
- Back-to-back: start asserted the cycle after done -> accepted; second result correct; first result held until second DONE.
